// File: rtl/regfile_decode_wb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_decode_wb
//  Purpose  : Y86-64 style register file with decode-stage operand selection,
//             write-back destination decode, write-back-to-decode bypass and
//             a registered (stallable) decode output stage.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst              : clock (rising edge), async active-high reset
//    dec_valid, stall      : decode valid / hold decode output registers
//    icode, rA, rB         : instruction being decoded
//    wb_valid              : write-back instruction valid
//    wb_icode, wb_rA, wb_rB: write-back instruction fields
//    wb_cnd                : condition outcome (cmovXX)
//    wb_valE, wb_valM      : write-back data (ALU result / memory result)
//    out_valid             : registered decode result valid
//    valA, valB            : registered operand values
//    srcA, srcB            : registered source indices
//    vflag                 : registered "reads two operands" flag
//    dbg_idx, dbg_data     : combinational register peek (no bypass)
// ============================================================================
module regfile_decode_wb #(
  parameter int DATA_W  = 64,
  parameter int NREGS   = 15,
  parameter int RSP_IDX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic              stall,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              wb_valid,
  input  logic [3:0]        wb_icode,
  input  logic [3:0]        wb_rA,
  input  logic [3:0]        wb_rB,
  input  logic              wb_cnd,
  input  logic [DATA_W-1:0] wb_valE,
  input  logic [DATA_W-1:0] wb_valM,
  output logic              out_valid,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic [3:0]        srcA,
  output logic [3:0]        srcB,
  output logic              vflag,
  input  logic [3:0]        dbg_idx,
  output logic [DATA_W-1:0] dbg_data
);

  // Instruction codes
  localparam logic [3:0] c_RRMOVQ = 4'h2;  // also cmovXX
  localparam logic [3:0] c_IRMOVQ = 4'h3;
  localparam logic [3:0] c_RMMOVQ = 4'h4;
  localparam logic [3:0] c_MRMOVQ = 4'h5;
  localparam logic [3:0] c_OPQ    = 4'h6;
  localparam logic [3:0] c_CALL   = 4'h8;
  localparam logic [3:0] c_RET    = 4'h9;
  localparam logic [3:0] c_PUSHQ  = 4'hA;
  localparam logic [3:0] c_POPQ   = 4'hB;

  localparam logic [3:0] c_RNONE  = 4'hF;
  localparam logic [3:0] c_RSP    = 4'(RSP_IDX);

  // --------------------------------------------------------------------------
  // Register array
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] r_regs [NREGS];

  // --------------------------------------------------------------------------
  // Decode: source selection and two-operand flag
  // --------------------------------------------------------------------------
  logic [3:0] w_src_a;
  logic [3:0] w_src_b;
  logic       w_vflag;

  always_comb begin
    w_src_a = c_RNONE;
    w_src_b = c_RNONE;
    w_vflag = 1'b0;

    case (icode)
      c_RRMOVQ, c_RMMOVQ, c_OPQ, c_PUSHQ: w_src_a = rA;
      c_RET, c_POPQ:                      w_src_a = c_RSP;
      default:                            w_src_a = c_RNONE;
    endcase

    case (icode)
      c_RMMOVQ, c_MRMOVQ, c_OPQ:          w_src_b = rB;
      c_CALL, c_RET, c_PUSHQ, c_POPQ:     w_src_b = c_RSP;
      default:                            w_src_b = c_RNONE;
    endcase

    case (icode)
      c_RMMOVQ, c_OPQ, c_RET, c_PUSHQ, c_POPQ: w_vflag = 1'b1;
      default:                                 w_vflag = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Write-back: destination selection
  // --------------------------------------------------------------------------
  logic [3:0] w_dst_e;
  logic [3:0] w_dst_m;

  always_comb begin
    w_dst_e = c_RNONE;
    w_dst_m = c_RNONE;

    case (wb_icode)
      c_IRMOVQ, c_OPQ:                w_dst_e = wb_rB;
      // cmovXX only commits when its condition held
      c_RRMOVQ:                       w_dst_e = wb_cnd ? wb_rB : c_RNONE;
      c_CALL, c_RET, c_PUSHQ, c_POPQ: w_dst_e = c_RSP;
      default:                        w_dst_e = c_RNONE;
    endcase

    case (wb_icode)
      c_MRMOVQ, c_POPQ: w_dst_m = wb_rA;
      default:          w_dst_m = c_RNONE;
    endcase
  end

  // A port is "active" only if the write-back is valid and the index maps
  // onto a real register; 4'hF and out-of-range indices never write or bypass.
  logic w_dst_e_ok;
  logic w_dst_m_ok;
  logic w_e_act;
  logic w_m_act;

  assign w_dst_e_ok = (w_dst_e != c_RNONE) && (int'(w_dst_e) < NREGS);
  assign w_dst_m_ok = (w_dst_m != c_RNONE) && (int'(w_dst_m) < NREGS);
  assign w_m_act    = wb_valid && w_dst_m_ok;
  // When both ports target the same register (popq %rsp) the M port wins,
  // so the E port is squashed for both write and bypass.
  assign w_e_act    = wb_valid && w_dst_e_ok && !(w_m_act && (w_dst_e == w_dst_m));

  // --------------------------------------------------------------------------
  // Register array update: one process per register
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_regs[gi] <= '0;
        end else if (w_m_act && (int'(w_dst_m) == gi)) begin
          r_regs[gi] <= wb_valM;
        end else if (w_e_act && (int'(w_dst_e) == gi)) begin
          r_regs[gi] <= wb_valE;
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Read ports: two decode reads and the debug peek. Unmatched indices
  // (4'hF, >= NREGS) fall through to zero.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic [DATA_W-1:0] w_rd_dbg;

  always_comb begin
    w_rd_a   = '0;
    w_rd_b   = '0;
    w_rd_dbg = '0;
    for (int i = 0; i < NREGS; i++) begin
      if ((w_src_a != c_RNONE) && (int'(w_src_a) == i)) w_rd_a   = r_regs[i];
      if ((w_src_b != c_RNONE) && (int'(w_src_b) == i)) w_rd_b   = r_regs[i];
      if ((dbg_idx != c_RNONE) && (int'(dbg_idx) == i)) w_rd_dbg = r_regs[i];
    end
  end

  assign dbg_data = w_rd_dbg;

  // --------------------------------------------------------------------------
  // Bypass: the write-back in flight this cycle overrides the array content.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;

  always_comb begin
    if (w_m_act && (w_src_a == w_dst_m)) begin
      w_op_a = wb_valM;
    end else if (w_e_act && (w_src_a == w_dst_e)) begin
      w_op_a = wb_valE;
    end else begin
      w_op_a = w_rd_a;
    end

    if (w_m_act && (w_src_b == w_dst_m)) begin
      w_op_b = wb_valM;
    end else if (w_e_act && (w_src_b == w_dst_e)) begin
      w_op_b = wb_valE;
    end else begin
      w_op_b = w_rd_b;
    end
  end

  // --------------------------------------------------------------------------
  // Decode output stage: loads every unstalled edge regardless of dec_valid;
  // out_valid simply tracks dec_valid.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      valA      <= '0;
      valB      <= '0;
      srcA      <= c_RNONE;
      srcB      <= c_RNONE;
      vflag     <= 1'b0;
    end else if (!stall) begin
      out_valid <= dec_valid;
      valA      <= w_op_a;
      valB      <= w_op_b;
      srcA      <= w_src_a;
      srcB      <= w_src_b;
      vflag     <= w_vflag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_decode_wb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_decode_wb
//  Purpose  : Self-checking bench for regfile_decode_wb. A table of directed
//             vectors (inputs + hand-computed post-edge outputs) is applied
//             one per clock, followed by hand-written stall and reset
//             sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_decode_wb;

  localparam int DATA_W = 64;

  logic              clk;
  logic              rst;
  logic              dec_valid;
  logic              stall;
  logic [3:0]        icode;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic              wb_valid;
  logic [3:0]        wb_icode;
  logic [3:0]        wb_rA;
  logic [3:0]        wb_rB;
  logic              wb_cnd;
  logic [DATA_W-1:0] wb_valE;
  logic [DATA_W-1:0] wb_valM;
  logic              out_valid;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic [3:0]        srcA;
  logic [3:0]        srcB;
  logic              vflag;
  logic [3:0]        dbg_idx;
  logic [DATA_W-1:0] dbg_data;

  regfile_decode_wb #(
    .DATA_W (DATA_W),
    .NREGS  (15),
    .RSP_IDX(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dec_valid(dec_valid),
    .stall    (stall),
    .icode    (icode),
    .rA       (rA),
    .rB       (rB),
    .wb_valid (wb_valid),
    .wb_icode (wb_icode),
    .wb_rA    (wb_rA),
    .wb_rB    (wb_rB),
    .wb_cnd   (wb_cnd),
    .wb_valE  (wb_valE),
    .wb_valM  (wb_valM),
    .out_valid(out_valid),
    .valA     (valA),
    .valB     (valB),
    .srcA     (srcA),
    .srcB     (srcB),
    .vflag    (vflag),
    .dbg_idx  (dbg_idx),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ov, input logic [63:0] va,
                            input logic [63:0] vb, input logic [3:0] sa,
                            input logic [3:0] sb, input logic vf);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
    check({tag, ".valA"},      valA,           va);
    check({tag, ".valB"},      valB,           vb);
    check({tag, ".srcA"},      64'(srcA),      64'(sa));
    check({tag, ".srcB"},      64'(srcB),      64'(sb));
    check({tag, ".vflag"},     64'(vflag),     64'(vf));
  endtask

  typedef struct {
    logic        dv;
    logic [3:0]  ic, ra, rb;
    logic        wv;
    logic [3:0]  wic, wra, wrb;
    logic        wc;
    logic [63:0] ve, vm;
    logic [3:0]  dbg;
    // expected after the edge
    logic        e_ov;
    logic [63:0] e_va, e_vb;
    logic [3:0]  e_sa, e_sb;
    logic        e_vf;
    logic [63:0] e_dbg;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic idle_inputs();
    dec_valid = 1'b0; stall = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF;
    wb_valid = 1'b0; wb_icode = 4'h1; wb_rA = 4'hF; wb_rB = 4'hF; wb_cnd = 1'b0;
    wb_valE = '0; wb_valM = '0; dbg_idx = 4'h0;
  endtask

  initial begin
    //            dv  ic    ra    rb    wv  wic   wra   wrb   wc  valE      valM     dbg   | ov  valA     valB     sA    sB    vf  dbg_data
    // irmovq r2=0x55 in WB, OPq r2,r2 in decode: bypass E into both operands
    vecs[0]  = '{1'b1,4'h6,4'h2,4'h2, 1'b1,4'h3,4'hF,4'h2,1'b0,64'h55,64'h0,   4'h2, 1'b1,64'h55,64'h55,4'h2,4'h2,1'b1,64'h55};
    // popq %rsp: E=0x108 and M=0x77 both target r4, M wins (write and bypass)
    vecs[1]  = '{1'b1,4'hB,4'h4,4'hF, 1'b1,4'hB,4'h4,4'hF,1'b0,64'h108,64'h77, 4'h4, 1'b1,64'h77,64'h77,4'h4,4'h4,1'b1,64'h77};
    // cmov not taken -> r3 unchanged; decode with dec_valid=0 still loads
    vecs[2]  = '{1'b0,4'h2,4'h3,4'h5, 1'b1,4'h2,4'h2,4'h3,1'b0,64'hAA,64'h0,   4'h3, 1'b0,64'h0,64'h0,  4'h3,4'hF,1'b0,64'h0};
    // cmov taken -> r3=0xAA, bypassed into rrmovq decode
    vecs[3]  = '{1'b1,4'h2,4'h3,4'h5, 1'b1,4'h2,4'h2,4'h3,1'b1,64'hAA,64'h0,   4'h3, 1'b1,64'hAA,64'h0, 4'h3,4'hF,1'b0,64'hAA};
    // wb_valid=0 -> no write to r5; rmmovq reads r3,r4 from the array
    vecs[4]  = '{1'b1,4'h4,4'h3,4'h4, 1'b0,4'h3,4'hF,4'h5,1'b0,64'h99,64'h0,   4'h5, 1'b1,64'hAA,64'h77,4'h3,4'h4,1'b1,64'h0};
    // write to 4'hF ignored; ret reads rsp twice; dbg of 4'hF reads 0
    vecs[5]  = '{1'b1,4'h9,4'h0,4'h0, 1'b1,4'h3,4'hF,4'hF,1'b0,64'h123,64'h0,  4'hF, 1'b1,64'h77,64'h77,4'h4,4'h4,1'b1,64'h0};
    // call updates rsp=0x100; pushq r2 bypasses E into srcB only
    vecs[6]  = '{1'b1,4'hA,4'h2,4'hF, 1'b1,4'h8,4'hF,4'hF,1'b0,64'h100,64'h0,  4'h4, 1'b1,64'h55,64'h100,4'h2,4'h4,1'b1,64'h100};
    // mrmovq r6=0x66 via M port; decode mrmovq: srcA none, srcB r6 bypass M
    vecs[7]  = '{1'b1,4'h5,4'h6,4'h6, 1'b1,4'h5,4'h6,4'hF,1'b0,64'h999,64'h66, 4'h6, 1'b1,64'h0,64'h66, 4'hF,4'h6,1'b0,64'h66};
    // call decode: srcB=rsp only
    vecs[8]  = '{1'b1,4'h8,4'h1,4'h2, 1'b0,4'h0,4'hF,4'hF,1'b0,64'h0,64'h0,   4'h2, 1'b1,64'h0,64'h100,4'hF,4'h4,1'b0,64'h55};
    // halt decode -> all none; OPq WB writes r7
    vecs[9]  = '{1'b1,4'h0,4'h1,4'h2, 1'b1,4'h6,4'h0,4'h7,1'b0,64'h7,64'h0,   4'h7, 1'b1,64'h0,64'h0,  4'hF,4'hF,1'b0,64'h7};
    // popq r1: rsp=0xF0 via E, r1=0x11 via M; OPq r1,r4 bypasses each
    vecs[10] = '{1'b1,4'h6,4'h1,4'h4, 1'b1,4'hB,4'h1,4'hF,1'b0,64'hF0,64'h11,  4'h1, 1'b1,64'h11,64'hF0,4'h1,4'h4,1'b1,64'h11};
    // highest valid register r14
    vecs[11] = '{1'b1,4'h2,4'hE,4'h0, 1'b1,4'h2,4'h0,4'hE,1'b1,64'hEE,64'h0,   4'hE, 1'b1,64'hEE,64'h0, 4'hE,4'hF,1'b0,64'hEE};
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int v = 0; v < NV; v++) begin
      dec_valid = vecs[v].dv;  stall = 1'b0;
      icode = vecs[v].ic; rA = vecs[v].ra; rB = vecs[v].rb;
      wb_valid = vecs[v].wv; wb_icode = vecs[v].wic;
      wb_rA = vecs[v].wra; wb_rB = vecs[v].wrb; wb_cnd = vecs[v].wc;
      wb_valE = vecs[v].ve; wb_valM = vecs[v].vm; dbg_idx = vecs[v].dbg;
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", v), vecs[v].e_ov, vecs[v].e_va, vecs[v].e_vb,
                 vecs[v].e_sa, vecs[v].e_sb, vecs[v].e_vf);
      check($sformatf("vec%0d.dbg_data", v), dbg_data, vecs[v].e_dbg);
      @(negedge clk);
    end

    // ---------------- stall sequence ----------------
    idle_inputs();
    dec_valid = 1'b1; icode = 4'h6; rA = 4'h1; rB = 4'h3;
    @(posedge clk); #1;
    check_outs("pre_stall", 1'b1, 64'h11, 64'hAA, 4'h1, 4'h3, 1'b1);
    @(negedge clk);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      dec_valid = 1'b0;
      icode     = 4'(c);              // halt/nop/rrmovq while frozen
      rA        = 4'h2; rB = 4'h2;
      wb_valid  = (c == 1);
      wb_icode  = 4'h3; wb_rB = 4'h8; wb_valE = 64'h88;
      dbg_idx   = 4'h8;
      @(posedge clk); #1;
      check_outs($sformatf("stall%0d", c), 1'b1, 64'h11, 64'hAA, 4'h1, 4'h3, 1'b1);
      @(negedge clk);
    end
    check("stall_wb.dbg_data", dbg_data, 64'h88);
    stall = 1'b0; wb_valid = 1'b0;
    dec_valid = 1'b1; icode = 4'h6; rA = 4'h8; rB = 4'h7;
    @(posedge clk); #1;
    check_outs("post_stall", 1'b1, 64'h88, 64'h7, 4'h8, 4'h7, 1'b1);

    // ---------------- async reset mid-cycle ----------------
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 1'b0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0);
    for (int r = 0; r < 15; r++) begin
      dbg_idx = 4'(r);
      #1;
      check($sformatf("async_rst.reg%0d", r), dbg_data, 64'h0);
    end
    // write-back coincident with reset must be ignored
    wb_valid = 1'b1; wb_icode = 4'h3; wb_rB = 4'h9; wb_valE = 64'hDEAD; dbg_idx = 4'h9;
    stall = 1'b0;
    @(posedge clk); #1;
    check("rst_wb_ignored", dbg_data, 64'h0);
    #2;
    rst = 1'b0;                       // deassert between edges
    #1;
    check("after_rst_before_edge", dbg_data, 64'h0);
    @(posedge clk); #1;
    check("first_write_after_rst", dbg_data, 64'hDEAD);
    check_outs("first_edge_after_rst", 1'b1, 64'h0, 64'h0, 4'h8, 4'h7, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global guard so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected completion before 100000");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/regfile_decode_wb.md
REGFILE_DECODE_WB -- requirements
Module: regfile_decode_wb

Interface
REQ-001 SHALL have parameter DATA_W, default 64: register and data width in bits.
REQ-002 SHALL have parameter NREGS, default 15: number of architectural registers; index 4'hF is "none".
REQ-003 SHALL have parameter RSP_IDX, default 4: stack-pointer register index.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port dec_valid, input, 1: decode-stage instruction valid.
REQ-007 SHALL have port stall, input, 1: holds the registered decode outputs.
REQ-008 SHALL have ports icode, rA and rB, each input, 4: the instruction being decoded.
REQ-009 SHALL have port wb_valid, input, 1: write-back instruction valid.
REQ-010 SHALL have ports wb_icode, wb_rA and wb_rB, each input, 4: the write-back instruction fields.
REQ-011 SHALL have port wb_cnd, input, 1: condition result used for cmovXX.
REQ-012 SHALL have ports wb_valE and wb_valM, each input, DATA_W: write-back data.
REQ-013 SHALL have port out_valid, output, 1: the registered decode result is valid.
REQ-014 SHALL have ports valA and valB, each output, DATA_W: registered operands.
REQ-015 SHALL have ports srcA and srcB, each output, 4: registered source indices.
REQ-016 SHALL have port vflag, output, 1: registered "instruction reads two operands" flag.
REQ-017 SHALL have port dbg_idx, input, 4, and port dbg_data, output, DATA_W: combinational register peek.

Function
REQ-018 SHALL hold NREGS registers of DATA_W bits each.
REQ-019 SHALL read 0 for any index equal to 4'hF or at least NREGS.
REQ-020 SHALL ignore writes to any index equal to 4'hF or at least NREGS.
REQ-021 SHALL select srcA as rA for icode 2, 4, 6 and A; as RSP_IDX for icode 9 and B; else 4'hF.
REQ-022 SHALL select srcB as rB for icode 4, 5 and 6; as RSP_IDX for icode 8, 9, A and B; else 4'hF.
REQ-023 SHALL set vflag to 1 for icode 4, 6, 9, A and B, and to 0 otherwise.
REQ-024 SHALL set dstE to wb_rB for icode 3 and 6; to wb_rB for icode 2 only when wb_cnd=1; to RSP_IDX for icode 8, 9, A and B; else 4'hF.
REQ-025 SHALL set dstM to wb_rA for icode 5 and B; else 4'hF.
REQ-026 SHALL, when wb_valid=1 at a rising edge, write wb_valE to dstE and wb_valM to dstM.
REQ-027 SHALL write only wb_valM when dstE equals dstM (popq %rsp case: M wins).
REQ-028 SHALL bypass write-back data to the decode read in the same cycle: if srcX equals an active dstM, use wb_valM; else if srcX equals an active dstE, use wb_valE; else use the register content.
REQ-029 SHALL register the decode result with 1-cycle latency: on an edge with stall=0, load valA, valB, srcA, srcB and vflag, and set out_valid to dec_valid.
REQ-030 SHALL hold all decode output registers while stall=1.
REQ-031 SHALL not block write-back when stall=1.
REQ-032 SHALL apply REQ-029 irrespective of dec_valid, with out_valid tracking dec_valid.
REQ-033 SHALL drive dbg_data combinationally from the register array, with no bypass.

Reset
REQ-034 SHALL, while rst=1, asynchronously clear all registers, valA, valB and vflag to 0.
REQ-035 SHALL, while rst=1, clear out_valid to 0 and set srcA and srcB to 4'hF.
REQ-036 SHALL ignore any write-back coincident with an asserted rst.
REQ-037 SHALL perform the first write on the first rising edge after rst deasserts.

Verification
REQ-038 SHALL pass: reset, then irmovq (wb_icode=3, wb_rB=2, wb_valE=0x55) -> dbg_idx=2 reads 0x55 the next cycle.
REQ-039 SHALL pass: OPq rA=2 rB=2 decoded in the same cycle as that write-back -> valA=valB=0x55 one cycle later, vflag=1.
REQ-040 SHALL pass: popq rA=4 with wb_valE=0x108 and wb_valM=0x77 -> register 4 = 0x77.
REQ-041 SHALL pass: cmovXX with wb_cnd=0 and wb_rB=3 -> register 3 unchanged; with wb_cnd=1 -> register 3 = wb_valE.
REQ-042 SHALL pass: stall=1 for 3 cycles while icode changes -> valA, valB, srcA, srcB, vflag and out_valid stay frozen, and a write-back in that window still updates the array.
REQ-043 SHALL pass: rst pulsed mid-operation between edges -> all outputs and registers read 0 immediately, with srcA=srcB=4'hF.
